// File: rtl/conv3x3_seq_ctrl.sv
// conv3x3_seq_ctrl: loads a 9-tap weight bank, then issues pixel/weight beats to the conv datapath.
// It tracks in-flight windows with a LAT-deep token line and strobes one result per window.
// Build macro CONV3X3_SEQ_CTRL_RELU_EN: when defined, negative results are clamped to 0 on capture.
module conv3x3_seq_ctrl #(
  parameter int X_BW  = 8,
  parameter int W_BW  = 8,
  parameter int O_BW  = 19,
  parameter int TAPS  = 9,
  parameter int LAT   = 32,
  parameter int NW_BW = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [NW_BW-1:0] i_num_win,
  input  logic             i_w_valid,
  output logic             o_w_ready,
  input  logic [W_BW-1:0]  i_w,
  input  logic             i_x_valid,
  output logic             o_x_ready,
  input  logic [X_BW-1:0]  i_x,
  output logic             o_dp_en,
  output logic [X_BW-1:0]  o_dp_x,
  output logic [W_BW-1:0]  o_dp_w,
  output logic [O_BW-1:0]  o_dp_psum,
  input  logic [O_BW-1:0]  i_dp_y,
  output logic             o_y_valid,
  output logic [O_BW-1:0]  o_y,
  output logic             o_busy,
  output logic             o_done
);

  localparam int TAP_BW = $clog2(TAPS);
  localparam int OUT_BW = $clog2(LAT + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic [W_BW-1:0]     wbank_q [TAPS];
  logic [TAP_BW-1:0]   wcnt_q;
  logic [TAP_BW-1:0]   tap_q;
  logic [NW_BW-1:0]    num_win_q;
  logic [NW_BW-1:0]    wincnt_q;
  logic [LAT-1:0]      tok_q, tok_d;
  logic [OUT_BW-1:0]   outst_q, outst_d;
  logic                dp_en_q;
  logic [X_BW-1:0]     dp_x_q;
  logic [W_BW-1:0]     dp_w_q;
  logic [O_BW-1:0]     dp_psum_q;
  logic                y_valid_q;
  logic [O_BW-1:0]     y_q, y_d;

  logic w_hs, x_hs, last_tap, tok_in, tok_out;

  // Handshakes and token line endpoints
  assign o_w_ready = (state_q == S_LOAD_W);
  assign o_x_ready = (state_q == S_RUN);
  assign w_hs      = i_w_valid & o_w_ready;
  assign x_hs      = i_x_valid & o_x_ready;
  assign last_tap  = (tap_q == TAP_BW'(TAPS - 1));
  assign tok_in    = x_hs & last_tap;
  assign tok_out   = tok_q[LAT-1];

  // Token shift: a 1 enters on the tap-8 issue and falls out LAT cycles later
  always_comb begin
    tok_d    = '0;
    tok_d[0] = tok_in;
    for (int i = 1; i < LAT; i++) tok_d[i] = tok_q[i-1];
  end

  // Outstanding windows: entry and exit in the same cycle cancel
  always_comb begin
    outst_d = outst_q;
    if (tok_in && !tok_out)      outst_d = outst_q + OUT_BW'(1);
    else if (!tok_in && tok_out) outst_d = outst_q - OUT_BW'(1);
  end

  // Result capture, optionally clamping negatives
  always_comb begin
`ifdef CONV3X3_SEQ_CTRL_RELU_EN
    y_d = i_dp_y[O_BW-1] ? '0 : i_dp_y;
`else
    y_d = i_dp_y;
`endif
  end

  // Job FSM: weight load, pixel issue, drain of in-flight windows
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      tap_q     <= '0;
      num_win_q <= '0;
      wincnt_q  <= '0;
      tok_q     <= '0;
      outst_q   <= '0;
      for (int i = 0; i < TAPS; i++) wbank_q[i] <= '0;
    end else begin
      tok_q   <= tok_d;
      outst_q <= outst_d;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            num_win_q <= i_num_win;
            wcnt_q    <= '0;
            tap_q     <= '0;
            wincnt_q  <= '0;
            state_q   <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (w_hs) begin
            wbank_q[wcnt_q] <= i_w;
            if (wcnt_q == TAP_BW'(TAPS - 1)) begin
              wcnt_q  <= '0;
              state_q <= (num_win_q == '0) ? S_DONE : S_RUN;
            end else begin
              wcnt_q <= wcnt_q + TAP_BW'(1);
            end
          end
        end
        S_RUN: begin
          if (x_hs) begin
            if (last_tap) begin
              tap_q    <= '0;
              wincnt_q <= wincnt_q + NW_BW'(1);
              if (wincnt_q == num_win_q - NW_BW'(1)) state_q <= S_DRAIN;
            end else begin
              tap_q <= tap_q + TAP_BW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (outst_q == '0) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath issue registers: one beat per accepted pixel, zeroed on bubbles
  always_ff @(posedge i_clk) begin
    if (i_rst || !x_hs) begin
      dp_en_q   <= 1'b0;
      dp_x_q    <= '0;
      dp_w_q    <= '0;
      dp_psum_q <= '0;
    end else begin
      dp_en_q   <= 1'b1;
      dp_x_q    <= i_x;
      dp_w_q    <= wbank_q[tap_q];
      dp_psum_q <= '0;
    end
  end

  // Result strobe follows the token at the end of the line; o_y holds between strobes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      y_valid_q <= 1'b0;
      y_q       <= '0;
    end else begin
      y_valid_q <= tok_out;
      if (tok_out) y_q <= y_d;
    end
  end

  assign o_dp_en   = dp_en_q;
  assign o_dp_x    = dp_x_q;
  assign o_dp_w    = dp_w_q;
  assign o_dp_psum = dp_psum_q;
  assign o_y_valid = y_valid_q;
  assign o_y       = y_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// Bench for conv3x3_seq_ctrl: random jobs against a window-level reference model.
// The model rebuilds each window's dot product from the beats it expects and plays the datapath.
module tb_conv3x3_seq_ctrl;
  localparam int X_BW = 8, W_BW = 8, O_BW = 19, TAPS = 9, LAT = 32, NW_BW = 16;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic [NW_BW-1:0] i_num_win = '0;
  logic             i_w_valid = 1'b0;
  logic [W_BW-1:0]  i_w = '0;
  logic             i_x_valid = 1'b0;
  logic [X_BW-1:0]  i_x = '0;
  logic [O_BW-1:0]  i_dp_y = '0;
  logic             o_w_ready, o_x_ready, o_dp_en, o_y_valid, o_busy, o_done;
  logic [X_BW-1:0]  o_dp_x;
  logic [W_BW-1:0]  o_dp_w;
  logic [O_BW-1:0]  o_dp_psum, o_y;

  conv3x3_seq_ctrl #(.X_BW(X_BW), .W_BW(W_BW), .O_BW(O_BW), .TAPS(TAPS), .LAT(LAT), .NW_BW(NW_BW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_win(i_num_win),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w(i_w),
    .i_x_valid(i_x_valid), .o_x_ready(o_x_ready), .i_x(i_x),
    .o_dp_en(o_dp_en), .o_dp_x(o_dp_x), .o_dp_w(o_dp_w), .o_dp_psum(o_dp_psum),
    .i_dp_y(i_dp_y), .o_y_valid(o_y_valid), .o_y(o_y), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { int cyc; int x; int w; bit last; } beat_t;
  typedef struct { int cyc; int val; } res_t;

  beat_t bq[$];    // expected datapath beats
  res_t  dpq[$];   // results the model datapath will present on i_dp_y
  res_t  yq[$];    // expected result strobes
  int    acc = 0;
  int    wt[TAPS];
  int    wm[TAPS];
  int    px[$];
  beat_t mb;
  res_t  mr;
  int    n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int relu(input int v);
`ifdef CONV3X3_SEQ_CTRL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int rnd8();
    logic [7:0] v;
    v = 8'($urandom);
    return int'($signed(v));
  endfunction

  task automatic rnd_w();
    for (int i = 0; i < TAPS; i++) wt[i] = rnd8();
  endtask

  task automatic rnd_px(input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(rnd8());
  endtask

  // Monitor and datapath model, evaluated on the falling edge
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_dp_en) begin
        if (bq.size() == 0) chk("dp_unexpected", 1, 0);
        else begin
          mb = bq.pop_front();
          chk("dp_cyc", cyc, mb.cyc);
          chk("dp_x", $signed(o_dp_x), mb.x);
          chk("dp_w", $signed(o_dp_w), mb.w);
          chk("dp_psum", $signed(o_dp_psum), 0);
          acc = acc + mb.x * mb.w;
          if (mb.last) begin
            mr.cyc = cyc + LAT - 1; mr.val = acc;       dpq.push_back(mr);
            mr.cyc = cyc + LAT;     mr.val = relu(acc); yq.push_back(mr);
            acc = 0;
          end
        end
      end else begin
        chk("dp_bubble", {o_dp_x, o_dp_w, o_dp_psum}, 0);
      end
      if (dpq.size() > 0 && dpq[0].cyc <= cyc) begin
        mr = dpq.pop_front();
        i_dp_y = O_BW'(mr.val);
      end
      if (o_y_valid) begin
        if (yq.size() == 0) chk("y_unexpected", 1, 0);
        else begin
          mr = yq.pop_front();
          chk("y_cyc", cyc, mr.cyc);
          chk("y_val", $signed(o_y), mr.val);
        end
      end else if (yq.size() > 0 && yq[0].cyc < cyc) begin
        mr = yq.pop_front();
        chk("y_missing", 0, 1);
      end
    end
  end

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    bq.delete(); dpq.delete(); yq.delete(); acc = 0;
    @(posedge i_clk); #1;
    chk("rst_outputs", {o_w_ready, o_x_ready, o_dp_en, o_dp_x, o_dp_w, o_dp_psum,
                        o_y_valid, o_y, o_busy, o_done}, 0);
    i_rst = 1'b0;
  endtask

  // One job: start, weight load, pixel stream, then either wait for done or reset in drain
  task automatic run_job(input int nw, input int spct, input bit st4, input bit poke, input bit rdrain);
    int k, b, n, stalls, t_last, c_w, exp_done, ycnt;
    bit hs, poked;
    beat_t nb;
    i_start = 1'b1; i_num_win = NW_BW'(nw);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    k = 0; n = 0; c_w = cyc;
    while (k < TAPS && n < 500) begin
      i_w_valid = ($urandom_range(99) >= spct);
      i_w = W_BW'(wt[k]);
      hs = i_w_valid && o_w_ready;
      c_w = cyc;
      @(posedge i_clk); #1; n++;
      if (hs) begin wm[k] = wt[k]; k++; end
    end
    i_w_valid = 1'b0;
    chk("weights_loaded", k, TAPS);
    b = 0; n = 0; stalls = 0; poked = 0; t_last = cyc;
    while (b < nw * TAPS && n < 2000) begin
      if (st4 && b == 5 && stalls < 3) begin i_x_valid = 1'b0; stalls++; end
      else i_x_valid = ($urandom_range(99) >= spct);
      i_x = X_BW'(px[b]);
      if (poke && b == 10 && !poked) begin i_start = 1'b1; i_num_win = NW_BW'(nw + 3); poked = 1; end
      hs = i_x_valid && o_x_ready;
      if (hs) begin
        nb.cyc = cyc + 1; nb.x = px[b]; nb.w = wm[b % TAPS]; nb.last = ((b % TAPS) == TAPS - 1);
        bq.push_back(nb);
        t_last = cyc;
      end
      @(posedge i_clk); #1; n++;
      i_start = 1'b0;
      if (hs) b++;
    end
    chk("pixels_accepted", b, nw * TAPS);
    i_x_valid = 1'b1;  // pixels offered after the job must be ignored
    if (rdrain) begin
      repeat (3) begin @(posedge i_clk); #1; end
      chk("drain_state", {o_busy, o_w_ready, o_x_ready}, 3'b100);
      i_x_valid = 1'b0;
      do_reset();
      ycnt = 0;
      repeat (LAT + 5) begin @(posedge i_clk); #1; ycnt += int'(o_y_valid); end
      chk("y_after_reset", ycnt, 0);
      chk("idle_after_reset", o_busy, 0);
    end else begin
      exp_done = (nw == 0) ? c_w + 1 : t_last + LAT + 2;
      n = 0;
      while (!o_done && n < LAT + 60) begin @(posedge i_clk); #1; n++; end
      chk("done_seen", o_done, 1);
      chk("done_cyc", cyc, exp_done);
      @(posedge i_clk); #1;
      chk("done_one_cycle", o_done, 0);
      chk("idle_not_busy", o_busy, 0);
      i_x_valid = 1'b0;
      chk("beats_left", bq.size(), 0);
      chk("results_left", yq.size(), 0);
    end
  endtask

  initial begin
    do_reset();
    // Pixels offered with no job must never be accepted
    i_x_valid = 1'b1;
    repeat (5) begin @(posedge i_clk); #1; chk("idle_x_ready", o_x_ready, 0); end
    i_x_valid = 1'b0;

    // Single window: weights 1..9, pixels all 2 -> 90
    for (int i = 0; i < TAPS; i++) wt[i] = i + 1;
    px.delete();
    repeat (TAPS) px.push_back(2);
    run_job(1, 0, 0, 0, 0);
    chk("single_y", $signed(o_y), relu(90));

    // Three-cycle stall after tap 4
    rnd_w(); rnd_px(9);
    run_job(1, 0, 1, 0, 0);

    // Four back-to-back windows
    rnd_w(); rnd_px(36);
    run_job(4, 0, 0, 0, 0);

    // Random stalls with a start pulse injected mid-job
    rnd_w(); rnd_px(27);
    run_job(3, 30, 0, 1, 0);

    // Zero-window job
    rnd_w();
    run_job(0, 0, 0, 0, 0);

    // Second window sums to -5
    for (int i = 0; i < TAPS; i++) wt[i] = i + 1;
    px.delete();
    repeat (TAPS) px.push_back(2);
    px.push_back(-5);
    repeat (TAPS - 1) px.push_back(0);
    run_job(2, 0, 0, 0, 0);
    chk("neg_y", $signed(o_y), relu(-5));

    // Reset while two windows are still in flight
    rnd_w(); rnd_px(18);
    run_job(2, 0, 0, 0, 1);

    // Recovery job after the mid-job reset
    rnd_w(); rnd_px(9);
    run_job(1, 20, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
